ws2812b_rx_decoder: RTL and testbench

//  Receive side of the WS2812B one-wire LED protocol. Samples a serial WS2812B data line,

---
 rtl/ws2812b_rx_decoder.sv | 176 +++++++++++++++++
 tb/tb_ws2812b_rx_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder
// Receive side of the WS2812B one-wire LED protocol. The data line is
// synchronised, every high pulse is measured and classified by width into a
// 0 or 1 bit, and bits are assembled MSB first into 24-bit GRB pixels.
// A low period of T_RESET cycles (the latch gap) closes the frame.
// After reset, or after a protocol error, nothing is decoded until a full
// latch gap has been seen, so the decoder never starts mid-pixel.

module ws2812b_rx_decoder #(
  parameter int NUM_PIXELS = 64,
  parameter int T_MIN_H    = 5,
  parameter int T_THRESH   = 30,
  parameter int T_MAX_H    = 75,
  parameter int T_RESET    = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic [5:0]  pixel_idx,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [6:0]  frame_count,
  output logic        err,
  output logic        overflow
);

  localparam int LW = $clog2(T_RESET + 1);
  localparam int HW = $clog2(T_MAX_H + 2);

  localparam logic [LW-1:0] LOW_MAX  = LW'(T_RESET);
  localparam logic [LW-1:0] LOW_LAST = LW'(T_RESET - 1);
  localparam logic [HW-1:0] H_MIN    = HW'(T_MIN_H);
  localparam logic [HW-1:0] H_THR    = HW'(T_THRESH);
  localparam logic [HW-1:0] H_MAX    = HW'(T_MAX_H);
  localparam logic [6:0]    PIX_MAX  = 7'(NUM_PIXELS);

  typedef enum logic [1:0] {
    SYNC,
    LOW,
    HIGH
  } state_t;

  state_t        state;
  logic          din_meta;
  logic          ds;
  logic          ds_d;
  logic [LW-1:0] low_cnt;
  logic [HW-1:0] high_cnt;
  logic [23:0]   shift_reg;
  logic [4:0]    bit_cnt;
  logic [6:0]    pix_cnt;
  logic          bits_seen;

  logic          rise;
  logic          fall;
  logic          bit_val;
  logic [23:0]   shift_next;
  logic          gap_hit;

  assign rise       = ds & ~ds_d;
  assign fall       = ~ds & ds_d;
  assign bit_val    = (high_cnt >= H_THR);
  assign shift_next = {shift_reg[22:0], bit_val};
  // The latch gap completes on the cycle the low counter would reach T_RESET,
  // either while waiting in SYNC or after a normal low phase.
  assign gap_hit    = (state != HIGH) && !ds && (low_cnt == LOW_LAST);

  // Two-flop synchroniser for the asynchronous data line plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      ds       <= 1'b0;
      ds_d     <= 1'b0;
    end else begin
      din_meta <= din;
      ds       <= din_meta;
      ds_d     <= ds;
    end
  end

  // Pulse-measuring FSM, bit/pixel assembly and frame-end bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      low_cnt     <= '0;
      high_cnt    <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      bits_seen   <= 1'b0;
      pixel_data  <= '0;
      pixel_idx   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err         <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;

      case (state)
        SYNC: begin
          if (ds) begin
            low_cnt <= '0;
          end else if (low_cnt == LOW_LAST) begin
            low_cnt <= LOW_MAX;
            state   <= LOW;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= HW'(1);
          end else if (low_cnt != LOW_MAX) begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (fall) begin
            state   <= LOW;
            low_cnt <= LW'(1);
            if (high_cnt >= H_MIN) begin
              bits_seen <= 1'b1;
              shift_reg <= shift_next;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (pix_cnt < PIX_MAX) begin
                  pixel_data  <= shift_next;
                  pixel_idx   <= pix_cnt[5:0];
                  pixel_valid <= 1'b1;
                  pix_cnt     <= pix_cnt + 1'b1;
                end else begin
                  overflow <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else if (high_cnt >= H_MAX) begin
            err       <= 1'b1;
            state     <= SYNC;
            low_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end

        default: begin
          state   <= SYNC;
          low_cnt <= '0;
        end
      endcase

      if (gap_hit && bits_seen) begin
        frame_done  <= 1'b1;
        frame_count <= pix_cnt;
        err         <= (bit_cnt != 5'd0);
        pix_cnt     <= '0;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        bits_seen   <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// tb_ws2812b_rx_decoder
// Directed bench for the WS2812B receive decoder. Pixels are sent MSB first
// with configurable high widths, low times and optional glitches; a monitor
// records every strobe so each scenario can be compared against hand-computed
// expected values.

module tb_ws2812b_rx_decoder;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic [23:0] pixel_data;
  logic [5:0]  pixel_idx;
  logic        pixel_valid;
  logic        frame_done;
  logic [6:0]  frame_count;
  logic        err;
  logic        overflow;

  int pass_count  = 0;
  int check_count = 0;

  int t0h    = 20;
  int t1h    = 40;
  int tlo    = 4;
  int tper   = 0;
  int glitch = 0;

  int          pv_total     = 0;
  int          fd_total     = 0;
  int          err_total    = 0;
  int          both_total   = 0;
  logic [6:0]  fd_fc_last   = '0;
  logic        fd_err_last  = 1'b0;
  logic        fd_prev      = 1'b0;
  logic        ovf_after_fd = 1'b1;
  logic [23:0] pv_data_q[$];
  logic [5:0]  pv_idx_q[$];

  ws2812b_rx_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .pixel_data (pixel_data),
    .pixel_idx  (pixel_idx),
    .pixel_valid(pixel_valid),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .err        (err),
    .overflow   (overflow)
  );

  // 100 MHz-style free-running clock; only cycle counts matter to the decoder
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every strobe on the falling clock edge, away from the active edge
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_total <= pv_total + 1;
      pv_data_q.push_back(pixel_data);
      pv_idx_q.push_back(pixel_idx);
    end
    if (fd_prev) ovf_after_fd <= overflow;
    fd_prev <= frame_done;
    if (frame_done) begin
      fd_total    <= fd_total + 1;
      fd_fc_last  <= frame_count;
      fd_err_last <= err;
    end
    if (err) err_total <= err_total + 1;
    if (pixel_valid && frame_done) both_total <= both_total + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic sendGap();
    din = 1'b0;
    repeat (2520) @(negedge clk);
  endtask

  // Send the top nbits of value, MSB first, using the current timing settings
  task automatic applyStimulus(input logic [23:0] value, input int nbits);
    int h;
    for (int i = 0; i < nbits; i++) begin
      h   = value[23-i] ? t1h : t0h;
      din = 1'b1;
      repeat (h) @(negedge clk);
      din = 1'b0;
      repeat ((tper > 0) ? (tper - h) : tlo) @(negedge clk);
      if (glitch > 0) begin
        din = 1'b1;
        repeat (glitch) @(negedge clk);
        din = 1'b0;
        repeat (tlo) @(negedge clk);
      end
    end
  endtask

  task automatic useFastTiming();
    t0h = 6; t1h = 31; tlo = 2; tper = 0; glitch = 0;
  endtask

  initial begin
    int pv_base;
    int fd_base;
    int err_base;
    int lat;
    int bad_data;
    int bad_idx;

    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pixel_data", pixel_data, 24'h0);
    checkOutput("rst_pixel_idx", pixel_idx, 6'd0);
    checkOutput("rst_pixel_valid", pixel_valid, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_frame_count", frame_count, 7'd0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // Test 1: one pixel at nominal timing, with the strobe latency measured on the last bit
    $display("[TB] test 1: single pixel 0x00FF00");
    sendGap();
    t0h = 20; t1h = 40; tper = 62; tlo = 4; glitch = 0;
    pv_base = pv_total; fd_base = fd_total; err_base = err_total;
    applyStimulus(24'h00FF00, 23);
    din = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      lat++;
      if (pixel_valid) break;
    end
    checkOutput("t1_latency", lat, 3);
    sendGap();
    checkOutput("t1_pv_count", pv_total - pv_base, 1);
    checkOutput("t1_pixel_data", pv_data_q[pv_base], 24'h00FF00);
    checkOutput("t1_pixel_idx", pv_idx_q[pv_base], 6'd0);
    checkOutput("t1_fd_count", fd_total - fd_base, 1);
    checkOutput("t1_frame_count", fd_fc_last, 7'd1);
    checkOutput("t1_err_count", err_total - err_base, 0);

    // Test 2: full 64-pixel frame of the matrix driver pattern
    $display("[TB] test 2: 64 pixels 0x000002");
    useFastTiming();
    pv_base = pv_total; fd_base = fd_total; err_base = err_total;
    for (int p = 0; p < 64; p++) applyStimulus(24'h000002, 24);
    checkOutput("t2_overflow_pre_gap", overflow, 1'b0);
    sendGap();
    bad_data = 0; bad_idx = 0;
    for (int p = 0; p < 64 && (pv_base + p) < pv_total; p++) begin
      if (pv_data_q[pv_base+p] !== 24'h000002) bad_data++;
      if (pv_idx_q[pv_base+p] !== 6'(p)) bad_idx++;
    end
    checkOutput("t2_pv_count", pv_total - pv_base, 64);
    checkOutput("t2_bad_data", bad_data, 0);
    checkOutput("t2_bad_idx", bad_idx, 0);
    checkOutput("t2_fd_count", fd_total - fd_base, 1);
    checkOutput("t2_frame_count", fd_fc_last, 7'd64);
    checkOutput("t2_err_count", err_total - err_base, 0);

    // Test 3: 65 pixels, the last one overflows
    $display("[TB] test 3: 65 pixels overflow");
    pv_base = pv_total; fd_base = fd_total;
    for (int p = 0; p < 64; p++) applyStimulus(24'h000002, 24);
    repeat (2) @(negedge clk);
    checkOutput("t3_overflow_at_64", overflow, 1'b0);
    applyStimulus(24'h000002, 24);
    repeat (2) @(negedge clk);
    checkOutput("t3_overflow_at_65", overflow, 1'b1);
    sendGap();
    checkOutput("t3_pv_count", pv_total - pv_base, 64);
    checkOutput("t3_last_idx", pv_idx_q[pv_total-1], 6'd63);
    checkOutput("t3_fd_count", fd_total - fd_base, 1);
    checkOutput("t3_frame_count", fd_fc_last, 7'd64);
    checkOutput("t3_overflow_after_fd", ovf_after_fd, 1'b0);

    // Test 4: partial pixel of 12 bits closed by a gap
    $display("[TB] test 4: partial pixel");
    pv_base = pv_total; fd_base = fd_total; err_base = err_total;
    applyStimulus(24'hABC000, 12);
    sendGap();
    checkOutput("t4_pv_count", pv_total - pv_base, 0);
    checkOutput("t4_fd_count", fd_total - fd_base, 1);
    checkOutput("t4_frame_count", fd_fc_last, 7'd0);
    checkOutput("t4_err_with_fd", fd_err_last, 1'b1);
    checkOutput("t4_err_count", err_total - err_base, 1);

    // Test 5a: 3-cycle glitches between bits are ignored
    $display("[TB] test 5: glitches and long pulse");
    t0h = 20; t1h = 40; tlo = 8; tper = 0; glitch = 3;
    pv_base = pv_total; err_base = err_total;
    applyStimulus(24'hA5A5A5, 24);
    sendGap();
    checkOutput("t5a_pv_count", pv_total - pv_base, 1);
    checkOutput("t5a_pixel_data", pv_data_q[pv_base], 24'hA5A5A5);
    checkOutput("t5a_err_count", err_total - err_base, 0);

    // Test 5b: over-long high pulse, then resynchronise and decode again
    fd_base = fd_total; err_base = err_total;
    din = 1'b1;
    repeat (100) @(negedge clk);
    din = 1'b0;
    repeat (2000) @(negedge clk);
    checkOutput("t5b_err_count", err_total - err_base, 1);
    checkOutput("t5b_no_fd_before_gap", fd_total - fd_base, 0);
    repeat (700) @(negedge clk);
    useFastTiming();
    pv_base = pv_total; fd_base = fd_total; err_base = err_total;
    applyStimulus(24'h123456, 24);
    sendGap();
    checkOutput("t5b_pv_count", pv_total - pv_base, 1);
    checkOutput("t5b_pixel_data", pv_data_q[pv_base], 24'h123456);
    checkOutput("t5b_fd_count", fd_total - fd_base, 1);
    checkOutput("t5b_frame_count", fd_fc_last, 7'd1);
    checkOutput("t5b_err_count_after", err_total - err_base, 0);

    // Test 5c: width boundaries (5 = shortest 0, 29 = longest 0, 30 = shortest 1, 75 = longest 1, 4-cycle glitch ignored)
    pv_base = pv_total; err_base = err_total;
    t0h = 5; t1h = 30; tlo = 6; glitch = 4;
    applyStimulus(24'h5A3C81, 24);
    t0h = 29; t1h = 75; tlo = 6; glitch = 0;
    applyStimulus(24'hC30FF0, 24);
    sendGap();
    checkOutput("t5c_pv_count", pv_total - pv_base, 2);
    checkOutput("t5c_data0", pv_data_q[pv_base], 24'h5A3C81);
    checkOutput("t5c_data1", pv_data_q[pv_base+1], 24'hC30FF0);
    checkOutput("t5c_idx1", pv_idx_q[pv_base+1], 6'd1);
    checkOutput("t5c_frame_count", fd_fc_last, 7'd2);
    checkOutput("t5c_err_count", err_total - err_base, 0);

    // Test 6: asynchronous reset mid-pixel, then data without a gap is ignored
    $display("[TB] test 6: reset mid-frame");
    useFastTiming();
    applyStimulus(24'hFFFFFF, 10);
    din = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_pixel_data", pixel_data, 24'h0);
    checkOutput("t6_async_pixel_idx", pixel_idx, 6'd0);
    checkOutput("t6_async_frame_count", frame_count, 7'd0);
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pv_base = pv_total; fd_base = fd_total;
    applyStimulus(24'h00FF00, 24);
    applyStimulus(24'h00FF00, 24);
    sendGap();
    checkOutput("t6_no_pv_without_gap", pv_total - pv_base, 0);
    checkOutput("t6_no_fd_without_gap", fd_total - fd_base, 0);
    pv_base = pv_total; fd_base = fd_total;
    applyStimulus(24'h81C3E7, 24);
    sendGap();
    checkOutput("t6_pv_count", pv_total - pv_base, 1);
    checkOutput("t6_pixel_data", pv_data_q[pv_base], 24'h81C3E7);
    checkOutput("t6_pixel_idx", pv_idx_q[pv_base], 6'd0);
    checkOutput("t6_fd_count", fd_total - fd_base, 1);
    checkOutput("t6_frame_count", fd_fc_last, 7'd1);

    checkOutput("pv_and_fd_same_cycle", both_total, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
